// File: rtl/cpu_pkg.sv
// Shared CPU types: T-phase encoding, store sequencer states and address-offset helpers.
package cpu_pkg;

    localparam int unsigned ADR_W  = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {T1, T2, T3, T4} t_phase_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BYTE0, ST_BYTE1} store16_state_t;

    // Operands captured when a store is accepted
    typedef struct packed {
        logic              push;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] val;
    } store16_req_t;

    // Address offset for each byte: ascending store uses 0/+1, PUSH uses -1/-2
    function automatic logic signed [1:0] store_offset(input logic push, input logic second);
        logic signed [1:0] off;
        if (push) begin
            off = second ? 2'sb10 : 2'sb11;
        end else begin
            off = second ? 2'sb01 : 2'sb00;
        end
        return off;
    endfunction

    // Modulo-2^16 base plus sign-extended 2-bit offset
    function automatic logic [ADR_W-1:0] add_offset(input logic [ADR_W-1:0] base,
                                                    input logic signed [1:0] off);
        return base + {{(ADR_W-2){off[1]}}, off};
    endfunction

endpackage

// File: rtl/store16_seq.sv
// Emits a 16-bit value as two consecutive byte-write M-cycles (ascending store or PUSH).
module store16_seq
    import cpu_pkg::*;
#(
    parameter int unsigned DOUT_T = 1,
    parameter int unsigned WR_T   = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [1:0]        t_phase,
    input  logic              start,
    input  logic              push,
    input  logic [ADR_W-1:0]  adr_in,
    input  logic [DATA_W-1:0] val_in,
    output logic [ADR_W-1:0]  adr,
    output logic [BYTE_W-1:0] dout,
    output logic              wr,
    output logic              busy,
    output logic              done,
    output logic [ADR_W-1:0]  sp_out
);

    store16_state_t    state_q;
    store16_state_t    state_d;
    store16_req_t      req_q;
    logic [ADR_W-1:0]  sp_q;
    t_phase_t          phase;
    logic              last_t_c;
    logic              accept_c;
    logic              second_c;
    logic [BYTE_W-1:0] byte_c;

    assign phase    = t_phase_t'(t_phase);
    assign last_t_c = (phase == T4);
    // A new store is taken when idle, or at T4 of the last byte for back-to-back stores
    assign accept_c = start && last_t_c && (state_q == ST_IDLE || state_q == ST_BYTE1);
    assign sp_out   = sp_q;

    // State register; reset drops the bus immediately since all bus outputs decode from it
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch and final stack/address result, updated only on an accepted start
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            req_q <= '0;
            sp_q  <= '0;
        end else if (accept_c) begin
            req_q <= '{push: push, adr: adr_in, val: val_in};
            sp_q  <= add_offset(adr_in, store_offset(push, 1'b1));
        end
    end

    // Next-state: advance only at T4 boundaries
    always_comb begin
        state_d = state_q;
        if (last_t_c) begin
            case (state_q)
                ST_IDLE:  state_d = start ? ST_BYTE0 : ST_IDLE;
                ST_BYTE0: state_d = ST_BYTE1;
                ST_BYTE1: state_d = start ? ST_BYTE0 : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Bus outputs decoded from state and T-phase; nothing driven outside write M-cycles
    always_comb begin
        adr      = '0;
        dout     = '0;
        wr       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        second_c = (state_q == ST_BYTE1);
        byte_c   = (req_q.push ^ second_c) ? req_q.val[15:8] : req_q.val[7:0];
        if (state_q == ST_BYTE0 || state_q == ST_BYTE1) begin
            busy = 1'b1;
            adr  = add_offset(req_q.adr, store_offset(req_q.push, second_c));
            dout = (t_phase >= 2'(DOUT_T)) ? byte_c : '0;
            wr   = (t_phase >= 2'(WR_T));
            done = second_c && last_t_c;
        end
    end

endmodule

// File: tb/tb_store16_seq.sv
// Scoreboard bench for store16_seq: stimulus pushes expected writes, a negedge monitor checks them.
module tb_store16_seq;

    logic        clk;
    logic        nreset;
    logic [1:0]  t_phase;
    logic        start;
    logic        push;
    logic [15:0] adr_in;
    logic [15:0] val_in;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic        wr;
    logic        busy;
    logic        done;
    logic [15:0] sp_out;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    logic [15:0] done_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    store16_seq dut (
        .clk    (clk),
        .nreset (nreset),
        .t_phase(t_phase),
        .start  (start),
        .push   (push),
        .adr_in (adr_in),
        .val_in (val_in),
        .adr    (adr),
        .dout   (dout),
        .wr     (wr),
        .busy   (busy),
        .done   (done),
        .sp_out (sp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU sequencer model: T-phase advances 0,1,2,3 shortly after each rising edge
    initial begin
        t_phase = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            t_phase = t_phase + 2'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares bus activity of each write M-cycle against the scoreboard
    always @(negedge clk) begin
        if (nreset) begin
            if (!busy) begin
                chk("idle_bus", {15'd0, wr, dout, adr}, 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_write_cycle", {14'd0, t_phase, adr}, 32'hFFFF_FFFF);
            end else begin
                case (t_phase)
                    2'd0: chk("t1_adr_dout_wr", {7'd0, wr, dout, adr}, {16'd0, exp_q[0].a});
                    2'd1: chk("t2_dout_wr", {23'd0, wr, dout}, {24'd0, exp_q[0].d});
                    2'd2: chk("t3_wr", {31'd0, wr}, 32'd1);
                    default: begin
                        chk("t4_adr_dout_wr", {7'd0, wr, dout, adr},
                            {7'd0, 1'b1, exp_q[0].d, exp_q[0].a});
                        void'(exp_q.pop_front());
                    end
                endcase
            end
            if (done) begin
                chk("done_phase", {30'd0, t_phase}, 32'd3);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", {16'd0, sp_out}, 32'hFFFF_FFFF);
                end else begin
                    chk("sp_out_at_done", {16'd0, sp_out}, {16'd0, done_q.pop_front()});
                end
            end
        end
    end

    // Advance to the next T4 window (at most four clocks)
    task automatic wait_t4();
        do begin
            @(posedge clk);
            #2;
        end while (t_phase != 2'd3);
    endtask

    // Present a start for one clock; when it should be accepted, queue the hand-computed writes
    task automatic issue(input logic p, input logic [15:0] a, input logic [15:0] v, input bit acc,
                         input logic [15:0] a0, input logic [7:0] d0,
                         input logic [15:0] a1, input logic [7:0] d1, input logic [15:0] sp);
        push   = p;
        adr_in = a;
        val_in = v;
        start  = 1'b1;
        if (acc) begin
            exp_q.push_back('{a: a0, d: d0});
            exp_q.push_back('{a: a1, d: d1});
            done_q.push_back(sp);
        end
        @(posedge clk);
        #2;
        start  = 1'b0;
        push   = ~p;
        adr_in = 16'h0BAD;
        val_in = 16'hDEAD;
    endtask

    // Run one full store from an idle T4 window to its final T4
    task automatic store(input logic p, input logic [15:0] a, input logic [15:0] v,
                         input logic [15:0] a0, input logic [7:0] d0,
                         input logic [15:0] a1, input logic [7:0] d1, input logic [15:0] sp);
        wait_t4();
        issue(p, a, v, 1'b1, a0, d0, a1, d1, sp);
        wait_t4();
        wait_t4();
    endtask

    initial begin
        nreset = 1'b0;
        start  = 1'b0;
        push   = 1'b0;
        adr_in = 16'h0;
        val_in = 16'h0;
        #3;
        chk("reset_outputs", {11'd0, wr, busy, done, dout, adr}, 32'd0);
        chk("reset_sp_out", {16'd0, sp_out}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        nreset = 1'b1;

        // start outside T4 while idle is ignored
        wait_t4();
        @(posedge clk); #2;
        @(posedge clk); #2;
        issue(1'b0, 16'h4000, 16'h1111, 1'b0, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0);
        repeat (6) @(posedge clk);
        #2;
        chk("start_t2_ignored_busy", {31'd0, busy}, 32'd0);

        store(1'b0, 16'hC000, 16'hBEEF, 16'hC000, 8'hEF, 16'hC001, 8'hBE, 16'hC001);
        store(1'b1, 16'hFFFE, 16'h1234, 16'hFFFD, 8'h12, 16'hFFFC, 8'h34, 16'hFFFC);
        store(1'b0, 16'hFFFF, 16'h5A3C, 16'hFFFF, 8'h3C, 16'h0000, 8'h5A, 16'h0000);
        store(1'b1, 16'h0001, 16'hA55A, 16'h0000, 8'hA5, 16'hFFFF, 8'h5A, 16'hFFFF);
        wait_t4();
        chk("sp_out_held_idle", {16'd0, sp_out}, 32'h0000_FFFF);

        // Back-to-back stores with an ignored start during BYTE0
        issue(1'b0, 16'h1000, 16'h0102, 1'b1, 16'h1000, 8'h02, 16'h1001, 8'h01, 16'h1001);
        wait_t4();
        issue(1'b1, 16'h5555, 16'h9999, 1'b0, 16'h0, 8'h0, 16'h0, 8'h0, 16'h0);
        wait_t4();
        issue(1'b1, 16'h2000, 16'h0304, 1'b1, 16'h1FFF, 8'h03, 16'h1FFE, 8'h04, 16'h1FFE);
        chk("back_to_back_no_gap", {31'd0, busy}, 32'd1);
        wait_t4();
        wait_t4();

        // Reset during BYTE0 T3 aborts the store
        wait_t4();
        issue(1'b0, 16'h3000, 16'h7788, 1'b1, 16'h3000, 8'h88, 16'h3001, 8'h77, 16'h3001);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("byte0_t3_wr_before_reset", {31'd0, wr}, 32'd1);
        nreset = 1'b0;
        #1;
        chk("reset_wr_drops", {30'd0, wr, busy}, 32'd0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #2;
        nreset = 1'b1;
        repeat (16) @(posedge clk);
        #2;
        chk("reset_sp_out_cleared", {16'd0, sp_out}, 32'd0);
        chk("scoreboard_drained", exp_q.size() + done_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
